// File: rtl/foo_eval_responder.sv
// foo_eval_responder
//
// Hardware end of the foo eval transaction. Accepts one request (a, long_in)
// over a valid/ready handshake, keeps a running 64-bit sum of every accepted a,
// rotates long_in left by a[ROT_BITS-1:0] one bit per cycle (modulo 129), and
// returns (x, long_out) over a second valid/ready handshake.
//
// Optional feature: define FOO_EVAL_PENDING_EN to compile in a one-entry
// pending buffer. This buffer lets a second request be accepted while the
// first is still shifting or waiting for its response to be taken.
//
// Ports:
//   clk           in   clock, all state on rising edge
//   rst           in   asynchronous active-high reset
//   req_valid     in   request present
//   req_ready     out  responder can accept a request (registered state only)
//   req_a         in   [63:0]  operand a (low ROT_BITS bits = rotate count)
//   req_long_in   in   [128:0] operand long_in
//   rsp_valid     out  response present
//   rsp_ready     in   consumer accepts response
//   rsp_x         out  [63:0]  accumulator including this request's a
//   rsp_long_out  out  [128:0] long_in rotated left by the rotate count
module foo_eval_responder #(
  parameter int ROT_BITS = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [63:0]  req_a,
  input  logic [128:0] req_long_in,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [63:0]  rsp_x,
  output logic [128:0] rsp_long_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_e;

  state_e              state_q, state_d;
  logic [63:0]         acc_q, acc_d;
  logic [63:0]         rsp_x_q, rsp_x_d;
  logic [128:0]        data_q, data_d;
  logic [ROT_BITS-1:0] cnt_q, cnt_d;
  logic [ROT_BITS-1:0] req_rot;
  logic                req_fire;
  logic                rsp_fire;

`ifdef FOO_EVAL_PENDING_EN
  logic                pend_vld_q, pend_vld_d;
  logic [128:0]        pend_long_q, pend_long_d;
  logic [ROT_BITS-1:0] pend_rot_q, pend_rot_d;

  // While busy, one more request may be taken as long as the buffer is free.
  assign req_ready = (state_q == IDLE) || !pend_vld_q;
`else
  assign req_ready = (state_q == IDLE);
`endif

  assign req_rot      = req_a[ROT_BITS-1:0];
  assign req_fire     = req_valid && req_ready;
  assign rsp_fire     = rsp_valid && rsp_ready;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_x        = rsp_x_q;
  assign rsp_long_out = data_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rsp_x_d = rsp_x_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef FOO_EVAL_PENDING_EN
    pend_vld_d  = pend_vld_q;
    pend_long_d = pend_long_q;
    pend_rot_d  = pend_rot_q;
`endif

    // The sum advances at acceptance, so x is fixed in transfer order even
    // when the request waits in the pending buffer.
    if (req_fire) begin
      acc_d = acc_q + req_a;
    end

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          data_d  = req_long_in;
          cnt_d   = req_rot;
          rsp_x_d = acc_q + req_a;
          state_d = (req_rot != '0) ? SHIFT : RESP;
        end
      end

      SHIFT: begin
        data_d = {data_q[127:0], data_q[128]};
        cnt_d  = cnt_q - ROT_BITS'(1);
        if (cnt_q == ROT_BITS'(1)) begin
          state_d = RESP;
        end
`ifdef FOO_EVAL_PENDING_EN
        if (req_fire) begin
          pend_vld_d  = 1'b1;
          pend_long_d = req_long_in;
          pend_rot_d  = req_rot;
        end
`endif
      end

      RESP: begin
        if (rsp_fire) begin
          state_d = IDLE;
`ifdef FOO_EVAL_PENDING_EN
          if (pend_vld_q) begin
            // acc_q already includes the buffered a; no new request can be
            // accepted while the buffer is full, so acc_q is its x.
            data_d     = pend_long_q;
            cnt_d      = pend_rot_q;
            rsp_x_d    = acc_q;
            pend_vld_d = 1'b0;
            state_d    = (pend_rot_q != '0) ? SHIFT : RESP;
          end else if (req_fire) begin
            data_d  = req_long_in;
            cnt_d   = req_rot;
            rsp_x_d = acc_q + req_a;
            state_d = (req_rot != '0) ? SHIFT : RESP;
          end
`endif
        end
`ifdef FOO_EVAL_PENDING_EN
        else if (req_fire) begin
          pend_vld_d  = 1'b1;
          pend_long_d = req_long_in;
          pend_rot_d  = req_rot;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rsp_x_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rsp_x_q <= rsp_x_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FOO_EVAL_PENDING_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q  <= 1'b0;
      pend_long_q <= '0;
      pend_rot_q  <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_long_q <= pend_long_d;
      pend_rot_q  <= pend_rot_d;
    end
  end
`endif

endmodule
